// File: rtl/alu_seq.sv
// Multi-cycle parametrised ALU: single-step logic/arith, one-bit-per-cycle shifts,
// shift-add multiplier; all results and flags registered behind start/busy/done.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       cs,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] s_hi,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic             negative,
  output logic             busy,
  output logic             done
);

  localparam int CW = SHW + 1;

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010,
                         OP_SUB = 4'b0011, OP_SLT = 4'b0100, OP_SBC = 4'b0101,
                         OP_ADC = 4'b0110, OP_XOR = 4'b0111, OP_SLL = 4'b1000,
                         OP_SRL = 4'b1001, OP_SRA = 4'b1010, OP_MUL = 4'b1011;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [3:0]         op_r;
  logic [WIDTH-1:0]   a_r, b_r;
  logic               cin_r;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   sh_r;
  logic [2*WIDTH-1:0] prod_r;

  logic [SHW-1:0]     shamt, ld_shamt;
  logic [CW-1:0]      cnt_load;
  logic [WIDTH-1:0]   b_eff;
  logic               c_eff;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   sh_next;
  logic               sh_out;
  logic [WIDTH:0]     mul_add;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH-1:0]   res_s, res_hi;
  logic               res_c, res_v, res_z;

  always_comb begin
    ld_shamt = data_b[SHW-1:0];
    cnt_load = CW'(1);
    if (cs == OP_MUL)
      cnt_load = CW'(WIDTH);
    else if ((cs == OP_SLL || cs == OP_SRL || cs == OP_SRA) && ld_shamt != '0)
      cnt_load = {1'b0, ld_shamt};

    shamt = b_r[SHW-1:0];
    b_eff = (op_r == OP_SUB || op_r == OP_SBC) ? ~b_r : b_r;
    case (op_r)
      OP_ADC, OP_SBC: c_eff = cin_r;
      OP_SUB:         c_eff = 1'b1;
      default:        c_eff = 1'b0;
    endcase
    sum = {1'b0, a_r} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_eff};

    case (op_r)
      OP_SLL: begin sh_next = {sh_r[WIDTH-2:0], 1'b0}; sh_out = sh_r[WIDTH-1]; end
      OP_SRL: begin sh_next = {1'b0, sh_r[WIDTH-1:1]}; sh_out = sh_r[0]; end
      default: begin sh_next = {sh_r[WIDTH-1], sh_r[WIDTH-1:1]}; sh_out = sh_r[0]; end
    endcase

    // One shift-add step: conditionally add A into the upper half, then shift right.
    mul_add   = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + (prod_r[0] ? {1'b0, a_r} : '0);
    prod_next = {mul_add, prod_r[WIDTH-1:1]};

    res_s  = '0;
    res_hi = '0;
    res_c  = 1'b0;
    res_v  = 1'b0;
    case (op_r)
      OP_AND: res_s = a_r & b_r;
      OP_OR:  res_s = a_r | b_r;
      OP_XOR: res_s = a_r ^ b_r;
      OP_SLT: res_s = {{(WIDTH-1){1'b0}}, (a_r < b_r)};
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        res_s = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (a_r[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_SLL, OP_SRL, OP_SRA: begin
        res_s = (shamt == '0) ? sh_r : sh_next;
        res_c = (shamt == '0) ? 1'b0 : sh_out;
      end
      OP_MUL: begin
        res_s  = prod_next[WIDTH-1:0];
        res_hi = prod_next[2*WIDTH-1:WIDTH];
        res_c  = (prod_next[2*WIDTH-1:WIDTH] != '0);
      end
      default: ;
    endcase
    res_z = (op_r == OP_MUL) ? (prod_next == '0) : (res_s == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_r      <= '0;
      a_r       <= '0;
      b_r       <= '0;
      cin_r     <= 1'b0;
      cnt       <= '0;
      sh_r      <= '0;
      prod_r    <= '0;
      s         <= '0;
      s_hi      <= '0;
      zero      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      negative  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_r   <= cs;
            a_r    <= data_a;
            b_r    <= data_b;
            cin_r  <= carry_in;
            cnt    <= cnt_load;
            sh_r   <= data_a;
            prod_r <= {{WIDTH{1'b0}}, data_b};
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          sh_r   <= sh_next;
          prod_r <= prod_next;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            s         <= res_s;
            s_hi      <= res_hi;
            zero      <= res_z;
            carry_out <= res_c;
            overflow  <= res_v;
            negative  <= res_s[WIDTH-1];
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the team's 8-bit combinational ALU.
- Width is a parameter, and all outputs are registered behind a start/busy/done handshake.
- The opcode set extends to XOR, barrel-free shifts (one bit per cycle) and an unsigned shift-add multiplier with a double-width product.
- Full N/Z/C/V flags are produced.
- It sits between the datapath register file and the result bus of the teaching CPU.

## Interface
Parameters:
- WIDTH, 8: operand/result width; power of two, at least 4.
- SHW, $clog2(WIDTH): shift-amount width, derived; not to be overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- cs  input  4  opcode, latched on accept.
- data_a  input  WIDTH  operand A, latched on accept.
- data_b  input  WIDTH  operand B, latched on accept.
- carry_in  input  1  carry/borrow input for ADC/SBC, latched on accept.
- s  output  WIDTH  result (low half for MUL).
- s_hi  output  WIDTH  MUL high half; 0 for every other op.
- zero, carry_out, overflow, negative  output  1 each  flags of last completed op.
- busy  output  1  an operation is in progress.
- done  output  1  one-cycle pulse; s/s_hi/flags valid from this cycle.

## Operation
Opcodes; unsigned unless noted.
- 0000 AND: a & b.
- 0001 OR: a | b.
- 0010 ADD: a + b.
- 0011 SUB: a - b.
- 0100 SLT: s = (a < b) ? 1 : 0.
- 0101 SBC: a - b - 1 + carry_in.
- 0110 ADC: a + b + carry_in.
- 0111 XOR: a ^ b.
- 1000 SLL: a << shamt.
- 1001 SRL: a >> shamt, logical.
- 1010 SRA: a >> shamt, arithmetic.
- 1011 MUL: {s_hi, s} = a * b, 2*WIDTH bits.
- 1100-1111: reserved; s = 0, s_hi = 0, zero = 1, other flags 0.
- shamt = data_b[SHW-1:0], i.e. b mod WIDTH.

Arithmetic and flag rules:
- ADD/ADC/SUB/SBC computed as a (WIDTH+1)-bit sum a + b' + c, where:
  - ADD: b' = b, c = 0.
  - ADC: b' = b, c = carry_in.
  - SUB: b' = ~b, c = 1.
  - SBC: b' = ~b, c = carry_in.
- carry_out = bit WIDTH of that sum, so for SUB/SBC carry = NOT borrow (SUB: carry_out = 1 iff a >= b).
- overflow (ADD/ADC/SUB/SBC): sign(a) == sign(b') and sign(s) != sign(a). Otherwise 0 (MUL included).
- Shifts: carry_out = last bit shifted out; 0 when shamt = 0.
- MUL: carry_out = (s_hi != 0).
- Logic/SLT/reserved: carry_out = 0.
- zero = (s == 0), except MUL, where zero = ({s_hi, s} == 0).
- negative = s[WIDTH-1].

FSM, states IDLE and RUN:
- IDLE: busy = 0. On an edge with start = 1, latch cs/a/b/carry_in, load the step counter, and go to RUN.
- Step counts:
  - single-step ops (logic, add/sub, SLT, reserved): 1.
  - shifts: max(1, shamt); each step shifts one bit.
  - MUL: WIDTH; each step does one shift-add on the partial product.
- RUN: busy = 1. Each edge performs one step and decrements the counter.
- On the final step, write s/s_hi/flags, set done = 1 for exactly one cycle, and return to IDLE.
- start while busy = 1 is ignored, with no queuing.
- start in the done cycle is accepted, since the state is IDLE: back-to-back operation.
- Outputs hold their values until the next done. Intermediate shift/multiply values are never visible on s.
- rst (async, any time, including mid-RUN):
  - state becomes IDLE and the counter clears;
  - s, s_hi, zero, carry_out, overflow, negative, busy and done all become 0 immediately;
  - the in-flight op is discarded with no done.

## Timing
- Accept edge = k, i.e. start = 1 and busy = 0 at edge k.
- Single-step op: busy is high in cycle k..k+1, the result is registered at edge k+1, done is high in the cycle after edge k+1.
  - Latency is 2 edges.
  - Throughput is one op per 2 cycles.
- Shift: done follows edge k + max(1, shamt).
- MUL: done follows edge k + WIDTH; busy stays high for WIDTH cycles.
- Inputs are don't-care after edge k.

## Test plan
All scenarios use WIDTH = 8.
- Reset then idle: all outputs read 0.
- ADD a=0xF0, b=0x20, start at edge k: done follows edge k+1 with s=0x10, carry_out=1, zero=0, overflow=0, negative=0.
- SUB and SBC:
  - SUB 0x05 - 0x05: s=0x00, zero=1, carry_out=1.
  - SBC a=0x05, b=0x05, carry_in=0: s=0xFF, carry_out=0, negative=1.
  - ADD 0x7F + 0x01: s=0x80, overflow=1.
- MUL 0xFF * 0xFF: busy for 8 cycles, then s_hi=0xFE, s=0x01, carry_out=1.
  - start pulsed mid-operation is ignored.
  - A new ADD issued in the done cycle completes 2 edges later.
- Shifts:
  - SRA 0x80 by 3: s=0xF0, carry_out=0, done after 3 steps.
  - SLL 0x81 by 1: s=0x02, carry_out=1.
  - SRL with b=0x08 (shamt 0): s=a, carry_out=0, done after 1 step.
- Assert rst 4 cycles into a MUL: busy, done, s and s_hi drop to 0 asynchronously, and no done pulse follows. A reserved opcode 0xC then yields s=0 with zero=1.
